// File: rtl/clock_pkg.sv
// Shared definitions for the alarm-clock time path: entry FSM encoding,
// BCD digit limits and HH:MM field positions.
package clock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENTRY  = 3'd1,
        ST_CHECK  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_ERROR  = 3'd4
    } entry_state_e;

    localparam logic [3:0] MAX_MS_HOUR      = 4'd2;
    localparam logic [3:0] MAX_LS_HOUR_AT_2 = 4'd3;
    localparam logic [3:0] MAX_MS_MIN       = 4'd5;
    localparam logic [3:0] MAX_BCD          = 4'd9;

    localparam int MS_HOUR_LSB = 12;
    localparam int LS_HOUR_LSB = 8;
    localparam int MS_MIN_LSB  = 4;
    localparam int LS_MIN_LSB  = 0;

    function automatic logic [3:0] hhmm_digit(input logic [15:0] value, input int lsb);
        return value[lsb +: 4];
    endfunction

endpackage

// File: rtl/bcd_time_check.sv
// Combinational legality test of a packed BCD HH:MM value (00:00 .. 23:59).
// Shared by the keypad entry path and the clock counter load path.
module bcd_time_check
    import clock_pkg::*;
(
    input  logic [15:0] value,
    output logic        legal
);

    logic [3:0] ms_hour;
    logic [3:0] ls_hour;
    logic [3:0] ms_min;
    logic [3:0] ls_min;

    assign ms_hour = hhmm_digit(value, MS_HOUR_LSB);
    assign ls_hour = hhmm_digit(value, LS_HOUR_LSB);
    assign ms_min  = hhmm_digit(value, MS_MIN_LSB);
    assign ls_min  = hhmm_digit(value, LS_MIN_LSB);

    assign legal = (ms_hour <= MAX_MS_HOUR)
                && ((ms_hour != MAX_MS_HOUR) || (ls_hour <= MAX_LS_HOUR_AT_2))
                && (ls_hour <= MAX_BCD)
                && (ms_min <= MAX_MS_MIN)
                && (ls_min <= MAX_BCD);

endmodule

// File: rtl/time_entry_ctrl.sv
// Keypad HH:MM entry sequencer: assembles digits, range-checks them and
// issues a one-cycle load strobe to the time counter or alarm register.
//
//   state  | meaning
//   IDLE   | no entry in progress, display shows time/alarm
//   ENTRY  | collecting digits, entry shown, timeout running
//   CHECK  | one cycle, range-check of the assembled value
//   COMMIT | one cycle, load strobe to the latched target
//   ERROR  | one cycle, rejection pulse, then back to ENTRY
module time_entry_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TMO_W          = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        set_time,
    input  logic        set_alarm,
    input  logic        cancel,
    output logic [15:0] entry_value,
    output logic        show_entry,
    output logic        load_time,
    output logic        load_alarm,
    output logic        entry_error,
    output logic [2:0]  digit_count
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    entry_state_e      state, state_nxt;
    logic [15:0]       entry_nxt;
    logic [2:0]        count_nxt;
    logic [TMO_W-1:0]  tmo_cnt, tmo_nxt, tmo_inc;
    logic              target_alarm, target_nxt;
    logic              value_legal;
    logic              key_ok;

    bcd_time_check u_check (
        .value (entry_value),
        .legal (value_legal)
    );

    assign key_ok  = key_valid && (key_digit <= MAX_BCD);
    assign tmo_inc = tmo_cnt + TMO_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            entry_value  <= 16'h0000;
            digit_count  <= 3'd0;
            tmo_cnt      <= '0;
            target_alarm <= 1'b0;
        end else begin
            state        <= state_nxt;
            entry_value  <= entry_nxt;
            digit_count  <= count_nxt;
            tmo_cnt      <= tmo_nxt;
            target_alarm <= target_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        entry_nxt  = entry_value;
        count_nxt  = digit_count;
        tmo_nxt    = tmo_cnt;
        target_nxt = target_alarm;
        case (state)
            ST_IDLE: begin
                tmo_nxt = '0;
                if (key_ok) begin
                    entry_nxt = {12'h000, key_digit};
                    count_nxt = 3'd1;
                    state_nxt = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (cancel) begin
                    state_nxt = ST_IDLE;
                    count_nxt = 3'd0;
                    tmo_nxt   = '0;
                end else if (set_time) begin
                    target_nxt = 1'b0;
                    state_nxt  = ST_CHECK;
                end else if (set_alarm) begin
                    target_nxt = 1'b1;
                    state_nxt  = ST_CHECK;
                end else if (key_valid) begin
                    // Any key press, even a non-digit, counts as activity.
                    tmo_nxt = '0;
                    if (key_ok) begin
                        entry_nxt = {entry_value[11:0], key_digit};
                        count_nxt = (digit_count == 3'd4) ? 3'd4 : digit_count + 3'd1;
                    end
                end else if (tmo_inc == TMO_LAST) begin
                    state_nxt = ST_IDLE;
                    count_nxt = 3'd0;
                    tmo_nxt   = '0;
                end else begin
                    tmo_nxt = tmo_inc;
                end
            end
            ST_CHECK: begin
                state_nxt = (value_legal && (digit_count != 3'd0)) ? ST_COMMIT : ST_ERROR;
            end
            ST_COMMIT: begin
                state_nxt = ST_IDLE;
                count_nxt = 3'd0;
            end
            ST_ERROR: begin
                state_nxt = ST_ENTRY;
                tmo_nxt   = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                count_nxt = 3'd0;
                tmo_nxt   = '0;
            end
        endcase
    end

    assign show_entry  = (state == ST_ENTRY);
    assign load_time   = (state == ST_COMMIT) && !target_alarm;
    assign load_alarm  = (state == ST_COMMIT) && target_alarm;
    assign entry_error = (state == ST_ERROR);

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Directed bench for time_entry_ctrl with a short timeout (8 cycles).
module tb_time_entry_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        set_time;
    logic        set_alarm;
    logic        cancel;
    logic [15:0] entry_value;
    logic        show_entry;
    logic        load_time;
    logic        load_alarm;
    logic        entry_error;
    logic [2:0]  digit_count;

    int checks = 0;
    int errors = 0;

    time_entry_ctrl #(.TIMEOUT_CYCLES(8), .TMO_W(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .set_time    (set_time),
        .set_alarm   (set_alarm),
        .cancel      (cancel),
        .entry_value (entry_value),
        .show_entry  (show_entry),
        .load_time   (load_time),
        .load_alarm  (load_alarm),
        .entry_error (entry_error),
        .digit_count (digit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick();
        key_valid = 1'b0;
        key_digit = 4'h0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset_n   = 1'b0;
        key_valid = 1'b0;
        key_digit = 4'h0;
        set_time  = 1'b0;
        set_alarm = 1'b0;
        cancel    = 1'b0;
        #3;
        chk("rst_value", entry_value, 16'h0000);
        chk("rst_count", 16'(digit_count), 16'd0);
        chk("rst_show", 16'(show_entry), 16'd0);
        chk("rst_strobes", 16'({load_time, load_alarm, entry_error}), 16'd0);
        #9 reset_n = 1'b1;
        tick();

        // async reset in the middle of an entry
        press(4'd1);
        press(4'd2);
        chk("mid_value", entry_value, 16'h0012);
        chk("mid_count", 16'(digit_count), 16'd2);
        chk("mid_show", 16'(show_entry), 16'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_value", entry_value, 16'h0000);
        chk("async_count", 16'(digit_count), 16'd0);
        chk("async_show", 16'(show_entry), 16'd0);
        reset_n = 1'b1;
        tick();

        // 12:34 to the alarm register, load exactly 2 clocks after set_alarm
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        chk("alm_value", entry_value, 16'h1234);
        chk("alm_count", 16'(digit_count), 16'd4);
        set_alarm = 1'b1;
        tick();
        set_alarm = 1'b0;
        chk("alm_check_no_load", 16'({load_time, load_alarm, entry_error}), 16'd0);
        chk("alm_check_show", 16'(show_entry), 16'd0);
        tick();
        chk("alm_load", 16'({load_time, load_alarm, entry_error}), 16'b010);
        chk("alm_load_value", entry_value, 16'h1234);
        tick();
        chk("alm_load_done", 16'({load_time, load_alarm, entry_error}), 16'd0);
        chk("alm_idle_count", 16'(digit_count), 16'd0);
        chk("alm_idle_show", 16'(show_entry), 16'd0);

        // five digits, oldest drops off: 73:05 rejected, then corrected to 23:59
        press(4'd0); press(4'd7); press(4'd3); press(4'd0); press(4'd5);
        chk("err_value", entry_value, 16'h7305);
        chk("err_count_sat", 16'(digit_count), 16'd4);
        set_time = 1'b1;
        tick();
        set_time = 1'b0;
        tick();
        chk("err_pulse", 16'({load_time, load_alarm, entry_error}), 16'b001);
        tick();
        chk("err_pulse_end", 16'({load_time, load_alarm, entry_error}), 16'd0);
        chk("err_back_entry", 16'(show_entry), 16'd1);
        chk("err_keep_count", 16'(digit_count), 16'd4);
        chk("err_keep_value", entry_value, 16'h7305);
        press(4'd2); press(4'd3); press(4'd5); press(4'd9);
        set_time = 1'b1;
        tick();
        set_time = 1'b0;
        tick();
        chk("fix_load", 16'({load_time, load_alarm, entry_error}), 16'b100);
        chk("fix_value", entry_value, 16'h2359);
        tick();

        // cancel beats a same-cycle set_time; set_time in IDLE is ignored
        press(4'd9);
        cancel   = 1'b1;
        set_time = 1'b1;
        tick();
        cancel   = 1'b0;
        set_time = 1'b0;
        chk("cancel_show", 16'(show_entry), 16'd0);
        chk("cancel_count", 16'(digit_count), 16'd0);
        chk("cancel_value", entry_value, 16'h0009);
        tick();
        chk("cancel_no_load", 16'({load_time, load_alarm, entry_error}), 16'd0);
        set_time = 1'b1;
        tick();
        set_time = 1'b0;
        tick();
        chk("idle_set_ignored", 16'({load_time, load_alarm, entry_error, show_entry}), 16'd0);

        // timeout after 7 idle ENTRY cycles
        press(4'd5);
        ticks(6);
        chk("tmo_still_entry", 16'(show_entry), 16'd1);
        tick();
        chk("tmo_expired", 16'(show_entry), 16'd0);
        chk("tmo_count", 16'(digit_count), 16'd0);

        // key at idle cycle 6 restarts the count
        press(4'd5);
        ticks(5);
        press(4'd6);
        chk("tmo_restart_value", entry_value, 16'h0056);
        ticks(6);
        chk("tmo_restart_alive", 16'(show_entry), 16'd1);
        tick();
        chk("tmo_restart_expired", 16'(show_entry), 16'd0);

        // short entry is right-aligned; non-digit key ignored
        press(4'd4);
        press(4'd5);
        press(4'hB);
        chk("bad_key_value", entry_value, 16'h0045);
        chk("bad_key_count", 16'(digit_count), 16'd2);
        chk("bad_key_show", 16'(show_entry), 16'd1);
        set_time = 1'b1;
        tick();
        set_time = 1'b0;
        tick();
        chk("short_load", 16'({load_time, load_alarm, entry_error}), 16'b100);
        chk("short_value", entry_value, 16'h0045);
        tick();
        chk("short_done", 16'({load_time, load_alarm, entry_error}), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_entry_ctrl.md
Name: time_entry_ctrl

Overview:
- Keypad entry sequencer for the alarm clock: accepts BCD digit key presses and assembles a 4-digit HH:MM value.
- Range-checks the value, then configures the clock datapath with a one-cycle load strobe to either the time counter or the alarm register.
- Owns the entry display mux request and the entry timeout.
- Sits between the keypad debouncer and the clock counter / alarm register / display driver.

Parameters:
- TIMEOUT_CYCLES, 1000, idle cycles in ENTRY with no key before entry is abandoned (min 2).
- TMO_W, 10, width of the timeout counter; must satisfy 2**TMO_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset; the decided form is "one clock; reset is asynchronous and active-low"
- key_valid  input  1  single-cycle strobe, digit key pressed
- key_digit  input  4  BCD digit qualified by key_valid; values 10-15 are ignored
- set_time  input  1  single-cycle strobe, commit entry as current time
- set_alarm  input  1  single-cycle strobe, commit entry as alarm time
- cancel  input  1  single-cycle strobe, abandon entry
- entry_value  output  16  {ms_hour, ls_hour, ms_min, ls_min} being entered
- show_entry  output  1  display driver shows entry_value instead of the time/alarm
- load_time  output  1  one-cycle strobe, clock counter loads entry_value
- load_alarm  output  1  one-cycle strobe, alarm register loads entry_value
- entry_error  output  1  high for exactly one cycle when a commit is rejected
- digit_count  output  3  digits entered so far, 0-4

Behaviour:
- Reset (async, reset_n=0): state IDLE, entry_value=16'h0000, digit_count=0, timeout counter=0, all strobes 0, show_entry=0.
- States: IDLE, ENTRY, CHECK, COMMIT, ERROR. A target register (time/alarm) is latched on the commit request.
- IDLE:
  - show_entry=0.
  - A valid key (key_digit<=9) clears the other digits, sets entry_value={12'h000,key_digit}, digit_count=1, and moves to ENTRY.
  - set_time, set_alarm and cancel are ignored.
- ENTRY:
  - show_entry=1.
  - Valid key: entry_value <= {entry_value[11:0], key_digit}; digit_count saturates at 4 (the oldest digit falls off the top); timeout counter clears.
  - Invalid key (digit>9): no shift, but the timeout still clears.
- Priority in one cycle (ENTRY): cancel > set_time > set_alarm > key.
  - cancel: go to IDLE, entry_value unchanged, digit_count=0.
  - set_time/set_alarm: latch target, go to CHECK. A same-cycle key is dropped.
- Timeout: the counter increments each ENTRY cycle without key_valid. At TIMEOUT_CYCLES-1, go to IDLE with digit_count=0.
- CHECK (one cycle):
  - Legal when digit_count>=1, ms_hour<=2, ms_hour==2 implies ls_hour<=3, ms_min<=5.
  - Fewer than 4 digits is legal; the digits are right-aligned and the upper digits are 0.
  - Legal goes to COMMIT; otherwise ERROR.
- COMMIT (one cycle):
  - Assert load_time or load_alarm per the target; entry_value is stable this cycle.
  - Next state IDLE, digit_count=0.
  - Latency: commit strobe into the block to load strobe out is exactly 2 clocks.
- ERROR (one cycle): entry_error=1, next state ENTRY. Digits are retained for correction and the timeout counter clears.
- Inputs in CHECK/COMMIT/ERROR are ignored (dropped, not queued).
- load_time, load_alarm and entry_error are mutually exclusive and never asserted outside COMMIT/ERROR.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Undefined state encodings recover to IDLE with digit_count=0.

Decomposition:
- Shared package clock_pkg:
  - state encoding constants (3-bit);
  - BCD digit limits (MAX_MS_HOUR=2, MAX_LS_HOUR_AT_2=3, MAX_MS_MIN=5);
  - the 16-bit HH:MM field slice positions.
- Sub-module bcd_time_check: combinational legality test of a 16-bit HH:MM value. It is reusable by the clock counter's load path.
- The timeout counter stays inline.

Test Plan:
- Reset mid-entry: after keys 1,2 assert reset_n=0 -> entry_value=0000, digit_count=0, show_entry=0 immediately (asynchronous).
- Keys 1,2,3,4 then set_alarm -> CHECK next cycle; load_alarm high exactly one cycle, 2 clocks after set_alarm, with entry_value=16'h1234; load_time stays 0.
- Keys 0,7,3,0,5 then set_time -> entry_value=16'h7305, ms_hour=7 is illegal, entry_error one cycle, return to ENTRY with digit_count=4. Then keys 2,3,5,9 and set_time -> load_time with 16'h2359.
- Key 9, then a same-cycle cancel and set_time -> IDLE, no load strobe; a later set_time in IDLE -> no response.
- TIMEOUT_CYCLES=8: key 5 then 7 idle cycles -> IDLE on the 8th cycle, show_entry falls. A key at idle cycle 6 restarts the count.
- Keys 4,5 then set_time -> value 16'h0045 legal, load_time asserted. Key_digit=4'hB in ENTRY -> no shift, digit_count unchanged.
